namuru_accum_status: RTL



---
 rtl/namuru_accum_status.sv | 92 +++++++++
 1 files changed

// File: rtl/namuru_accum_status.sv
// Accumulation status block for the Namuru correlator.
// It collects per-channel dump pulses into a pending mask. On each accumulation
// interrupt it publishes that mask as new_data and raises a maskable CPU irq.
// It also tracks the TIC sequence number, the TIC phase at interrupt time, and
// saturating missed-read and overrun statistics.
module namuru_accum_status #(
  parameter int NCH = 12,
  parameter int OVW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           accum_enable,
  input  logic           tic_enable,
  input  logic [23:0]    tic_count,
  input  logic [NCH-1:0] dump,
  input  logic           status_rd,
  input  logic           irq_mask,
  output logic           irq,
  output logic           accum_flag,
  output logic           tic_flag,
  output logic [NCH-1:0] new_data,
  output logic [23:0]    tic_phase,
  output logic [15:0]    tic_seq,
  output logic [OVW-1:0] missed_cnt,
  output logic [OVW-1:0] overrun_cnt
);

  logic [NCH-1:0] pend;
  logic           accum_flag_next;
  logic           missed_hit;
  logic           overrun_hit;

  // Flag set dominates a coincident status read; irq follows the next flag value.
  always_comb begin
    accum_flag_next = accum_enable | (accum_flag & ~status_rd);
    missed_hit      = accum_enable & accum_flag & ~status_rd;
    overrun_hit     = ~accum_enable & (|(pend & dump));
  end

  // Pending mask and snapshot. Dumps in the interrupt cycle belong to the closing period.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend      <= '0;
      new_data  <= '0;
      tic_phase <= '0;
    end else if (accum_enable) begin
      pend      <= '0;
      new_data  <= pend | dump;
      tic_phase <= tic_count;
    end else begin
      pend <= pend | dump;
    end
  end

  // Status flags and the registered interrupt.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      accum_flag <= 1'b0;
      tic_flag   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      accum_flag <= accum_flag_next;
      tic_flag   <= tic_enable | (tic_flag & ~status_rd);
      irq        <= accum_flag_next & ~irq_mask;
    end
  end

  // TIC sequence number, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tic_seq <= '0;
    end else if (tic_enable) begin
      tic_seq <= tic_seq + 16'd1;
    end
  end

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      missed_cnt  <= '0;
      overrun_cnt <= '0;
    end else begin
      if (missed_hit && (missed_cnt != '1)) begin
        missed_cnt <= missed_cnt + OVW'(1);
      end
      if (overrun_hit && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + OVW'(1);
      end
    end
  end

endmodule
